// File: rtl/pixel_compositor_pkg.sv
// Shared types and constants for the pixel compositor: fade FSM states,
// default layer count and the layer index assignments of the game objects.
package params;

    typedef enum logic [1:0] {
        BLACK    = 2'd0,
        FADE_IN  = 2'd1,
        SHOWN    = 2'd2,
        FADE_OUT = 2'd3
    } comp_fade_e;

    localparam int COMP_NUM_LAYERS = 6;

    localparam int LAYER_GAMEOVER = 0;
    localparam int LAYER_ALIEN    = 1;
    localparam int LAYER_PADDLE   = 2;
    localparam int LAYER_BULLET   = 3;

endpackage

// File: rtl/pixel_compositor_fade_controller.sv
// Frame-synchronous fade FSM: steps the brightness level every FRAMES_PER_STEP
// frames during fade-in/fade-out and pulses fade_done when a fade completes.
module fade_controller
    import params::*;
#(
    parameter int FADE_BITS       = 4,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                 pixel_clk,
    input  logic                 rst_n,
    input  logic                 fsync,
    input  logic                 fade_out_req,
    input  logic                 fade_in_req,
    output logic [FADE_BITS:0]   level,
    output logic [1:0]           fade_state,
    output logic                 fade_done
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [FADE_BITS:0] LVL_MAX  = {1'b1, {FADE_BITS{1'b0}}};
    localparam logic [FADE_BITS:0] LVL_ONE  = (FADE_BITS+1)'(1);

    comp_fade_e         state_q, state_d;
    logic [FADE_BITS:0] level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_next;
    logic               pend_q, pend_d, done_q, done_d;
    logic               in_req, step;

    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        in_req   = pend_q | fade_in_req;
        pend_d   = in_req;
        step     = (cnt_q == CNT_LAST);
        cnt_next = step ? '0 : cnt_q + CNT_W'(1);
        if (fsync) begin
            case (state_q)
                BLACK: begin
                    if (in_req) begin
                        state_d = FADE_IN;
                        pend_d  = 1'b0;
                    end
                end
                FADE_IN: begin
                    pend_d = 1'b0;
                    if (fade_out_req) begin
                        state_d = FADE_OUT;
                    end else if (level_q == LVL_MAX) begin
                        state_d = SHOWN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_next;
                        if (step) begin
                            level_d = level_q + LVL_ONE;
                            if (level_d == LVL_MAX) begin
                                state_d = SHOWN;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                SHOWN: begin
                    pend_d = 1'b0;
                    if (fade_out_req) state_d = FADE_OUT;
                end
                default: begin
                    // A held fade_out_req outranks a pending fade-in request.
                    if (in_req && !fade_out_req) begin
                        state_d = FADE_IN;
                        pend_d  = 1'b0;
                    end else if (level_q == '0) begin
                        state_d = BLACK;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_next;
                        if (step) begin
                            level_d = level_q - LVL_ONE;
                            if (level_d == '0) begin
                                state_d = BLACK;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
            endcase
            if (state_d != state_q) cnt_d = '0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state_q <= FADE_IN;
            level_q <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign level      = level_q;
    assign fade_state = state_q;
    assign fade_done  = done_q;

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage pixel compositor: priority layer select, then brightness fade.
// Define PIXEL_COMPOSITOR_COLLISION_EN to add per-frame layer overlap reporting.
module pixel_compositor
    import params::*;
#(
    parameter int NUM_LAYERS      = COMP_NUM_LAYERS,
    parameter int CW              = 8,
    parameter int FADE_BITS       = 4,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic                       pixel_clk,
    input  logic                       rst_n,
    input  logic                       fsync,
    input  logic                       active,
    input  logic [NUM_LAYERS-1:0]      layer_active,
    input  logic [NUM_LAYERS*3*CW-1:0] layer_pixel,
    input  logic [NUM_LAYERS-1:0]      layer_enable,
    input  logic [3*CW-1:0]            bg_color,
    input  logic                       fade_out_req,
    input  logic                       fade_in_req,
    output logic [3*CW-1:0]            pixel_out,
    output logic                       active_out,
    output logic [1:0]                 fade_state,
    output logic                       fade_done,
    output logic [NUM_LAYERS-1:0]      collision,
    output logic                       collision_valid
);

    localparam int PW = 3 * CW;

    logic [NUM_LAYERS-1:0] shadow_q, shadow_d;
    logic [PW-1:0]         s1_pix_q, s1_pix_d, pix_q, faded;
    logic [FADE_BITS:0]    level, s1_level_q;
    logic                  s1_act_q, act_q;

    fade_controller #(
        .FADE_BITS       (FADE_BITS),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_fade (
        .pixel_clk    (pixel_clk),
        .rst_n        (rst_n),
        .fsync        (fsync),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .level        (level),
        .fade_state   (fade_state),
        .fade_done    (fade_done)
    );

    always_comb begin
        shadow_d = fsync ? layer_enable : shadow_q;
        s1_pix_d = bg_color;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_active[i] && shadow_q[i]) s1_pix_d = layer_pixel[i*PW +: PW];
        end
        if (!active) s1_pix_d = '0;
    end

    // The level travels with the pixel so an fsync-cycle level change only hits later pixels.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [CW+FADE_BITS:0] prod;
        logic [CW:0]           scaled;
        assign prod   = {{(FADE_BITS+1){1'b0}}, s1_pix_q[gi*CW +: CW]} * {{CW{1'b0}}, s1_level_q};
        assign scaled = prod[CW+FADE_BITS:FADE_BITS];
        assign faded[gi*CW +: CW] = scaled[CW] ? {CW{1'b1}} : scaled[CW-1:0];
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            shadow_q   <= '1;
            s1_pix_q   <= '0;
            s1_act_q   <= 1'b0;
            s1_level_q <= '0;
            pix_q      <= '0;
            act_q      <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            s1_pix_q   <= s1_pix_d;
            s1_act_q   <= active;
            s1_level_q <= level;
            pix_q      <= faded;
            act_q      <= s1_act_q;
        end
    end

    assign pixel_out  = pix_q;
    assign active_out = act_q;

`ifdef PIXEL_COMPOSITOR_COLLISION_EN
    logic [NUM_LAYERS-1:0] cov_mask, hit_mask, sticky_q, sticky_d, coll_q;
    logic                  coll_valid_q;

    // The fsync-cycle pixel seeds the new frame's mask rather than the reported one.
    always_comb begin
        cov_mask = layer_active & shadow_q;
        hit_mask = '0;
        if (active && ((cov_mask & (cov_mask - NUM_LAYERS'(1))) != '0)) hit_mask = cov_mask;
        sticky_d = fsync ? hit_mask : (sticky_q | hit_mask);
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            sticky_q     <= '0;
            coll_q       <= '0;
            coll_valid_q <= 1'b0;
        end else begin
            sticky_q     <= sticky_d;
            coll_q       <= fsync ? sticky_q : coll_q;
            coll_valid_q <= fsync;
        end
    end

    assign collision       = coll_q;
    assign collision_valid = coll_valid_q;
`else
    assign collision       = '0;
    assign collision_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_compositor.sv
// Self-checking bench for pixel_compositor: reference model of compositing,
// fade and collision rules, fixed vector table plus randomized frames.
module tb_pixel_compositor;

    localparam int NL  = 6;
    localparam int CW  = 8;
    localparam int FB  = 4;
    localparam int FPS = 2;

    logic            pixel_clk = 1'b0;
    logic            rst_n, fsync, active, fade_out_req, fade_in_req;
    logic [NL-1:0]   layer_active, layer_enable;
    logic [NL*24-1:0] layer_pixel;
    logic [23:0]     bg_color;
    logic [23:0]     pixel_out;
    logic            active_out, fade_done, collision_valid;
    logic [1:0]      fade_state;
    logic [NL-1:0]   collision;

    pixel_compositor #(
        .NUM_LAYERS(NL), .CW(CW), .FADE_BITS(FB), .FRAMES_PER_STEP(FPS)
    ) dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .active(active),
        .layer_active(layer_active), .layer_pixel(layer_pixel), .layer_enable(layer_enable),
        .bg_color(bg_color), .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
        .pixel_out(pixel_out), .active_out(active_out), .fade_state(fade_state),
        .fade_done(fade_done), .collision(collision), .collision_valid(collision_valid)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_done_seen = 0;

    // reference model state
    int          m_state, m_level, m_cnt;
    bit          m_pend, m_cvalid;
    logic [NL-1:0] m_shadow, m_sticky, m_coll;
    logic [24:0] exp_q[$];

    typedef struct {
        logic [NL-1:0] en;
        logic [NL-1:0] la;
        logic          act;
        logic [23:0]   exp;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    function automatic logic [23:0] ref_pix(logic act, logic [NL-1:0] la, logic [NL-1:0] sh,
                                            logic [NL*24-1:0] lp, logic [23:0] bg, int lvl);
        logic [23:0] c, r;
        int v;
        c = '0;
        if (act) begin
            c = bg;
            for (int i = 0; i < NL; i++) begin
                if (la[i] && sh[i]) begin
                    c = lp[i*24 +: 24];
                    break;
                end
            end
        end
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            v = int'(c[ch*8 +: 8]) * lvl / 16;
            if (v > 255) v = 255;
            r[ch*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 1; m_level = 0; m_cnt = 0; m_pend = 0;
        m_shadow = '1; m_sticky = '0; m_coll = '0; m_cvalid = 0;
    endtask

    // Frame-boundary rules of the fade sequence.
    task automatic model_fsync(output bit done);
        bit inr;
        done = 0;
        inr = m_pend || fade_in_req;
        m_pend = inr;
        case (m_state)
            0: if (inr) begin m_state = 1; m_cnt = 0; m_pend = 0; end
            1: begin
                m_pend = 0;
                if (fade_out_req) begin m_state = 3; m_cnt = 0; end
                else begin
                    if (m_level < 16) begin
                        m_cnt++;
                        if (m_cnt == FPS) begin m_cnt = 0; m_level++; end
                    end
                    if (m_level == 16) begin m_state = 2; m_cnt = 0; done = 1; end
                end
            end
            2: begin
                m_pend = 0;
                if (fade_out_req) begin m_state = 3; m_cnt = 0; end
            end
            default: begin
                if (inr && !fade_out_req) begin m_state = 1; m_cnt = 0; m_pend = 0; end
                else begin
                    if (m_level > 0) begin
                        m_cnt++;
                        if (m_cnt == FPS) begin m_cnt = 0; m_level--; end
                    end
                    if (m_level == 0) begin m_state = 0; m_cnt = 0; done = 1; end
                end
            end
        endcase
    endtask

    // One clock: update model from current inputs, clock the DUT, compare outputs.
    task automatic step();
        logic [24:0]   e;
        logic [NL-1:0] cm, hit;
        bit            exp_done;
        exp_done = 0;
        if (!rst_n) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back('0);
            exp_q.push_back('0);
        end else begin
            exp_q.push_back({active, ref_pix(active, layer_active, m_shadow, layer_pixel, bg_color, m_level)});
            cm  = layer_active & m_shadow;
            hit = (active && $countones(cm) >= 2) ? cm : '0;
            if (fsync) begin
                m_coll = m_sticky; m_sticky = hit; m_cvalid = 1;
                model_fsync(exp_done);
                m_shadow = layer_enable;
            end else begin
                m_sticky = m_sticky | hit; m_cvalid = 0;
                m_pend = m_pend || fade_in_req;
            end
        end
        @(posedge pixel_clk);
        #1;
        cyc++;
        if (fade_done === 1'b1) n_done_seen++;
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk("pixel_out", 32'(pixel_out), 32'(e[23:0]));
            chk("active_out", 32'(active_out), 32'(e[24]));
        end
        chk("fade_state", 32'(fade_state), 32'(m_state));
        chk("fade_done", 32'(fade_done), 32'(exp_done));
`ifdef PIXEL_COMPOSITOR_COLLISION_EN
        chk("collision", 32'(collision), 32'(m_coll));
        chk("collision_valid", 32'(collision_valid), 32'(m_cvalid));
`else
        chk("collision_off", 32'(collision), 32'(0));
        chk("collision_valid_off", 32'(collision_valid), 32'(0));
`endif
    endtask

    task automatic rand_pix();
        active       = ($urandom_range(0, 7) != 0);
        layer_active = NL'($urandom & $urandom);
        bg_color     = 24'($urandom);
        for (int i = 0; i < NL; i++) layer_pixel[i*24 +: 24] = 24'($urandom);
    endtask

    task automatic frame(int len, bit rnd);
        fsync = 1'b1;
        if (rnd) rand_pix();
        step();
        fsync = 1'b0;
        for (int k = 1; k < len; k++) begin
            if (rnd) rand_pix();
            step();
        end
    endtask

    task automatic set_fixed_colours();
        layer_pixel[0*24 +: 24] = 24'h102030;
        layer_pixel[1*24 +: 24] = 24'hFF0000;
        layer_pixel[2*24 +: 24] = 24'h400000;
        layer_pixel[3*24 +: 24] = 24'h00FF00;
        layer_pixel[4*24 +: 24] = 24'h000000;
        layer_pixel[5*24 +: 24] = 24'h808080;
        bg_color = 24'h202020;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_base;
        vecs[0] = '{6'h3F, 6'b000110, 1'b1, 24'hFF0000};
        vecs[1] = '{6'h3F, 6'b000000, 1'b1, 24'h202020};
        vecs[2] = '{6'h3F, 6'b111111, 1'b0, 24'h000000};
        vecs[3] = '{6'h3D, 6'b000110, 1'b1, 24'h400000};
        vecs[4] = '{6'h3F, 6'b100001, 1'b1, 24'h102030};
        vecs[5] = '{6'h3E, 6'b100001, 1'b1, 24'h808080};
        vecs[6] = '{6'h00, 6'b111111, 1'b1, 24'h202020};
        vecs[7] = '{6'h3F, 6'b110000, 1'b1, 24'h000000};
        vecs[8] = '{6'h3F, 6'b101000, 1'b1, 24'h00FF00};

        rst_n = 1'b0; fsync = 1'b0; active = 1'b0; fade_out_req = 1'b0; fade_in_req = 1'b0;
        layer_active = '0; layer_enable = '1; layer_pixel = '0; bg_color = '0;
        model_reset();
        for (int k = 0; k < 3; k++) step();
        chk("reset_pixel", 32'(pixel_out), 32'(0));
        chk("reset_active", 32'(active_out), 32'(0));
        chk("reset_state", 32'(fade_state), 32'(1));
        chk("reset_done", 32'(fade_done), 32'(0));
        rst_n = 1'b1;
        $display("reset sequence done, cycle=%0d", cyc);

        // Fade-in from reset, with a half-brightness probe at level 8.
        done_base = n_done_seen;
        for (int f = 0; f < 16; f++) frame(4, 1'b1);
        layer_pixel[0 +: 24] = 24'hFFFFFF; layer_active = 6'b000001; active = 1'b1;
        step(); step();
        chk("level8_layer0", 32'(pixel_out), 32'h7F7F7F);
        layer_active = '0; bg_color = 24'h202020;
        step(); step();
        chk("level8_bg", 32'(pixel_out), 32'h101010);
        for (int f = 0; f < 16; f++) frame(4, 1'b1);
        chk("fade_in_shown", 32'(fade_state), 32'(2));
        chk("fade_in_done_pulses", 32'(n_done_seen - done_base), 32'(1));
        $display("fade-in sequence: state=%0d done pulses=%0d", fade_state, n_done_seen - done_base);

        // Priority table at full brightness.
        set_fixed_colours();
        for (int v = 0; v < 9; v++) begin
            layer_enable = vecs[v].en; active = 1'b0; layer_active = '0;
            frame(1, 1'b0);
            layer_active = vecs[v].la; active = vecs[v].act;
            step(); step();
            chk("table_pixel", 32'(pixel_out), 32'(vecs[v].exp));
            $display("vector %0d: en=%b la=%b act=%b pixel=%h expect=%h",
                     v, vecs[v].en, vecs[v].la, vecs[v].act, pixel_out, vecs[v].exp);
        end

        // Enable mask change mid-frame only applies after the next fsync.
        layer_enable = 6'h3F; frame(1, 1'b0);
        layer_active = 6'b000110; active = 1'b1;
        step();
        layer_enable = 6'h3D;
        step(); step();
        chk("mask_before_fsync", 32'(pixel_out), 32'hFF0000);
        fsync = 1'b1; step(); fsync = 1'b0;
        step(); step();
        chk("mask_after_fsync", 32'(pixel_out), 32'h400000);
        $display("mask sequence: pixel=%h", pixel_out);

`ifdef PIXEL_COMPOSITOR_COLLISION_EN
        layer_enable = 6'h3F; layer_active = '0; active = 1'b1;
        frame(2, 1'b0);
        layer_active = 6'b001100; step();
        layer_active = '0; step(); step();
        fsync = 1'b1; step(); fsync = 1'b0;
        chk("coll_mask", 32'(collision), 32'h0C);
        chk("coll_valid_pulse", 32'(collision_valid), 32'(1));
        step();
        chk("coll_valid_low", 32'(collision_valid), 32'(0));
        layer_active = 6'b000100; step(); step();
        fsync = 1'b1; step(); fsync = 1'b0;
        chk("coll_clear", 32'(collision), 32'(0));
        $display("collision sequence: mask=%b", collision);
`endif

        // Fade-out to black while layers remain active.
        layer_enable = 6'h3F; fade_out_req = 1'b1;
        for (int f = 0; f < 40 && m_state != 0; f++) frame(4, 1'b1);
        chk("fade_out_black", 32'(fade_state), 32'(0));
        set_fixed_colours();
        layer_active = 6'b111111; active = 1'b1;
        step(); step();
        chk("black_pixel", 32'(pixel_out), 32'(0));
        fade_out_req = 1'b0;
        fade_in_req = 1'b1; step(); fade_in_req = 1'b0;
        step(); step();
        chk("pending_waits_fsync", 32'(fade_state), 32'(0));
        frame(1, 1'b0);
        chk("restart_fade_in", 32'(fade_state), 32'(1));
        $display("fade-out sequence: state=%0d", fade_state);

        // Reverse to FADE_OUT at level 5, then reset mid-fade.
        for (int f = 0; f < 20 && m_level != 5; f++) frame(3, 1'b1);
        fade_out_req = 1'b1;
        frame(1, 1'b1);
        chk("reverse_fade_out", 32'(fade_state), 32'(3));
        chk("reverse_keeps_level", 32'(m_level), 32'(5));
        rst_n = 1'b0; step(); rst_n = 1'b1;
        fade_out_req = 1'b0;
        chk("midfade_reset_state", 32'(fade_state), 32'(1));
        chk("midfade_reset_pixel", 32'(pixel_out), 32'(0));
        chk("midfade_reset_active", 32'(active_out), 32'(0));
        chk("midfade_reset_done", 32'(fade_done), 32'(0));
        $display("mid-fade reset: state=%0d", fade_state);

        // Randomized frames with random requests and enable masks.
        for (int f = 0; f < 60; f++) begin
            int len;
            layer_enable = NL'($urandom);
            fade_out_req = ($urandom_range(0, 3) == 0);
            len = $urandom_range(2, 8);
            fsync = 1'b1;
            rand_pix(); fade_in_req = ($urandom_range(0, 7) == 0);
            step();
            fsync = 1'b0;
            for (int k = 1; k < len; k++) begin
                rand_pix(); fade_in_req = ($urandom_range(0, 7) == 0);
                step();
            end
        end
        fade_in_req = 1'b0;
        $display("random frames done: state=%0d level=%0d", m_state, m_level);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_compositor.md
# pixel_compositor

Parametrised successor to the fixed three-channel priority mux in the top level. It merges `NUM_LAYERS` sprite/overlay layers into one HDMI pixel through a registered priority stage, then applies a frame-synchronous fade (fade-in at start, fade-out on game over). Optionally, it reports per-frame inter-layer overlap for collision detection. It sits between the game objects (alien group, paddle, bullet, gameover controller) and `hdmi_transmit`.

## Interface
Parameters:
- `NUM_LAYERS`, 6: number of input layers; index 0 has highest priority.
- `CW`, 8: bits per colour channel.
- `FADE_BITS`, 4: fade level resolution; full brightness is level `2**FADE_BITS`.
- `FRAMES_PER_STEP`, 2: frames per fade level step, ≥1.

Ports:
- `pixel_clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `fsync`  in  1  one-cycle frame-start pulse.
- `active`  in  1  active video region.
- `layer_active`  in  NUM_LAYERS  per-layer coverage of the current pixel.
- `layer_pixel`  in  NUM_LAYERS×3×CW  per-layer colour; channel 0=blue, 1=green, 2=red.
- `layer_enable`  in  NUM_LAYERS  layer mask, sampled at `fsync`.
- `bg_color`  in  3×CW  colour used when no enabled layer covers the pixel.
- `fade_out_req`  in  1  level request, driven by game_over.
- `fade_in_req`  in  1  single-cycle request to restart the fade-in.
- `pixel_out`  out  3×CW  composited, faded pixel.
- `active_out`  out  1  `active` delayed to align with `pixel_out`.
- `fade_state`  out  2  current fade FSM state.
- `fade_done`  out  1  one-cycle pulse when a fade completes.
- `collision`  out  NUM_LAYERS  overlap mask for the previous frame (macro only).
- `collision_valid`  out  1  one-cycle pulse when `collision` updates (macro only).

## Operation
- **Enable mask.** A shadow copy of `layer_enable` loads on `fsync`. Its reset value is all ones.
- **Stage 1 (priority select).**
  - Winner = lowest index i with `layer_active[i] & enable_shadow[i]`.
  - Coverage is decided by `layer_active` alone; black pixels from active layers are opaque.
  - If no layer wins, output `bg_color`.
  - If `active` is 0, output 0.
- **Stage 2 (fade).**
  - Each channel = (c × level) >> FADE_BITS.
  - The product is CW+FADE_BITS+1 bits wide and is saturated to 2**CW−1.
  - level ranges 0..2**FADE_BITS.
- **Fade FSM.** States: BLACK=0, FADE_IN=1, SHOWN=2, FADE_OUT=3. Transitions are evaluated only on `fsync`.
  - FADE_IN: a frame counter counts `fsync`s. Every `FRAMES_PER_STEP` frames, level increments by 1. At level max, go to SHOWN and pulse `fade_done`.
  - SHOWN: if `fade_out_req`=1, go to FADE_OUT.
  - FADE_OUT: mirror of FADE_IN, decrementing level. At 0, go to BLACK and pulse `fade_done`.
  - BLACK: a pending `fade_in_req` moves to FADE_IN.
  - FADE_IN with `fade_out_req`=1: reverse to FADE_OUT, keeping the current level.
  - FADE_OUT with `fade_in_req` pending: reverse to FADE_IN.
  - If both requests are present on the same `fsync`, `fade_out_req` wins.
  - `fade_in_req` sets a pending flag. The flag clears when acted on, and also clears on `fsync` in SHOWN or FADE_IN.
  - The frame counter clears on every state change.

## Timing
- Pixel latency is 2 cycles: input at cycle n appears on `pixel_out`/`active_out` at n+2.
- Level and enable-mask changes on an `fsync` cycle apply to pixels sampled on the following cycle.
- `fade_done` is asserted in the cycle after the terminating `fsync`.
- **Reset values:**
  - `pixel_out`=0, `active_out`=0.
  - `fade_state`=FADE_IN, level=0, frame counter=0, pending flag=0.
  - `fade_done`=0, `collision`=0, `collision_valid`=0.
  - Pipeline registers are cleared.
- Reset asserted mid-fade returns to FADE_IN at level 0 on the next edge.
- With `FRAMES_PER_STEP`=2 and `FADE_BITS`=4, a full fade takes 32 `fsync`s.

## Configuration
- `PIXEL_COMPOSITOR_COLLISION_EN` defined:
  - A sticky mask accumulates over active pixels. When ≥2 enabled layers are active on the same pixel, each of those layers' bits is set.
  - On `fsync`, the sticky mask copies to `collision` and then clears. `collision_valid` pulses 1 cycle after `fsync`.
  - A pixel sampled on the `fsync` cycle counts toward the new frame.
- Macro undefined: the collision logic is removed; `collision`=0 and `collision_valid`=0 constantly.

## Structure
- The `params` package holds:
  - `comp_fade_e` enum (BLACK, FADE_IN, SHOWN, FADE_OUT).
  - `COMP_NUM_LAYERS`.
  - Layer index constants: LAYER_GAMEOVER=0, LAYER_ALIEN=1, LAYER_PADDLE=2, LAYER_BULLET=3.
- One sub-module, `fade_controller`, contains the FSM, frame counter, level and request flag. It outputs `level`, `fade_state` and `fade_done`.

## Test plan
1. Reset, then 32 `fsync`s with `fade_out_req`=0 → `fade_state`=SHOWN, one `fade_done` pulse. Layer1 red=0xFF and layer2 red=0x40 both active → `pixel_out` red=0xFF two cycles later.
2. Level 8 (16 frames after reset), layer0 all channels 0xFF → each channel 0x7F. With no layers active, `bg_color`=0x20 per channel → 0x10 per channel.
3. Clear `layer_enable[1]` mid-frame → layer1 still shown until the next `fsync`, then layer2 colour is shown.
4. In SHOWN, hold `fade_out_req`=1 → after 32 `fsync`s BLACK with `pixel_out`=0 despite active layers. Pulse `fade_in_req` → FADE_IN on the next `fsync`.
5. COLLISION_EN: layers 2 and 3 overlap on one pixel → after `fsync`, `collision`=6'b001100 and `collision_valid` pulses. Next frame with no overlap → `collision`=0.
6. Assert `rst_n`=0 at FADE_OUT level 5 → next cycle FADE_IN, level 0, all outputs at reset values.
